// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  localparam int unsigned HALT_IMMEDIATE     = 0;
  localparam int unsigned HALT_BOUNDARY      = 1;
  localparam int unsigned DEFAULT_NUM_PHASES = 3;

endpackage

// File: rtl/phase_sequencer_ring.sv
// Phase index ring: holds the next phase to emit, decodes it one-hot and
// flags the first and last phase of a machine cycle.
module phase_ring
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PHASES = DEFAULT_NUM_PHASES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adv,
  output logic [NUM_PHASES-1:0] onehot,
  output logic                  last,
  output logic                  at_first
);

  localparam int unsigned IW = $clog2(NUM_PHASES);

  logic [IW-1:0] idx_q, idx_d;

  // Wrap/first detect and one-hot decode of the current index.
  always_comb begin
    last     = (idx_q == IW'(NUM_PHASES - 1));
    at_first = (idx_q == '0);
    onehot   = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      onehot[i] = (idx_q == IW'(i));
    end
  end

  // Next index: advance on emit, wrapping after the last phase.
  always_comb begin
    idx_d = idx_q;
    if (adv) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase clock-enable generator with boundary/immediate halting,
// single-cycle stepping and a completed-cycle counter.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PHASES = DEFAULT_NUM_PHASES,
  parameter int unsigned HALT_MODE  = HALT_BOUNDARY,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  step,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  cycle_done,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  halted
);

  state_e                  state_q, state_d;
  logic [NUM_PHASES-1:0]   phase_q, phase_d;
  logic                    cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0]        cycle_count_q, cycle_count_d;
  logic                    halted_q, halted_d;

  logic                    emit;
  logic [NUM_PHASES-1:0]   ring_onehot;
  logic                    ring_last;
  logic                    ring_first;

  phase_ring #(
    .NUM_PHASES(NUM_PHASES)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .adv      (emit),
    .onehot   (ring_onehot),
    .last     (ring_last),
    .at_first (ring_first)
  );

  // Next-state, emit decision and registered output values.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!halt) begin
          emit = 1'b1;
        end else if (HALT_MODE == HALT_IMMEDIATE || ring_first) begin
          state_d = ST_HALTED;
        end else begin
          emit = 1'b1;
        end
      end
      ST_HALTED: begin
        if (!halt) begin
          emit    = 1'b1;
          state_d = ST_RUN;
        end else if (step) begin
          emit    = 1'b1;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        emit = 1'b1;
        if (!halt) begin
          state_d = ST_RUN;
        end else if (ring_last) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_RUN;
    endcase

    phase_d       = emit ? ring_onehot : '0;
    cycle_done_d  = emit && ring_last;
    cycle_count_d = (emit && ring_last) ? cycle_count_q + 1'b1 : cycle_count_q;
    halted_d      = (state_d == ST_HALTED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      phase_q       <= '0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
      halted_q      <= halted_d;
    end
  end

  assign phase       = phase_q;
  assign cycle_done  = cycle_done_q;
  assign cycle_count = cycle_count_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: three configurations share one stimulus stream
// and are compared every cycle against a phase-count reference model.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic reset, halt, step;

  logic [2:0]  phase_a;  logic done_a; logic [15:0] count_a; logic halted_a;
  logic [3:0]  phase_b;  logic done_b; logic [1:0]  count_b; logic halted_b;
  logic [3:0]  phase_c;  logic done_c; logic [15:0] count_c; logic halted_c;

  int total = 0;
  int bad   = 0;

  // Per-configuration model parameters: a = (3,boundary,16), b = (4,immediate,2), c = (4,boundary,16)
  int NP   [3] = '{3, 4, 4};
  int MODE [3] = '{1, 0, 1};
  int CW   [3] = '{16, 2, 16};

  // Model: total phases emitted since reset, plus halted/stepping flags.
  int emitted    [3];
  bit m_halted   [3];
  bit m_stepping [3];
  int exp_phase  [3];
  int exp_done   [3];

  phase_sequencer #(.NUM_PHASES(3), .HALT_MODE(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .halt(halt), .step(step),
    .phase(phase_a), .cycle_done(done_a), .cycle_count(count_a), .halted(halted_a));

  phase_sequencer #(.NUM_PHASES(4), .HALT_MODE(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .halt(halt), .step(step),
    .phase(phase_b), .cycle_done(done_b), .cycle_count(count_b), .halted(halted_b));

  phase_sequencer #(.NUM_PHASES(4), .HALT_MODE(1), .CNT_W(16)) dut_c (
    .clk(clk), .reset(reset), .halt(halt), .step(step),
    .phase(phase_c), .cycle_done(done_c), .cycle_count(count_c), .halted(halted_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step(input logic r, input logic h, input logic s);
    for (int k = 0; k < 3; k++) begin
      int n, pos;
      bit em;
      n  = NP[k];
      pos = emitted[k] % n;
      em = 1'b0;
      if (r) begin
        emitted[k]    = 0;
        m_halted[k]   = 1'b0;
        m_stepping[k] = 1'b0;
      end else if (m_halted[k]) begin
        if (!h) begin
          em = 1'b1; m_halted[k] = 1'b0;
        end else if (s) begin
          em = 1'b1; m_halted[k] = 1'b0; m_stepping[k] = 1'b1;
        end
      end else if (m_stepping[k]) begin
        em = 1'b1;
        if (!h) m_stepping[k] = 1'b0;
        else if (pos == n - 1) begin
          m_stepping[k] = 1'b0; m_halted[k] = 1'b1;
        end
      end else begin
        if (!h) em = 1'b1;
        else if (MODE[k] == 0 || pos == 0) m_halted[k] = 1'b1;
        else em = 1'b1;
      end
      exp_phase[k] = em ? (1 << pos) : 0;
      exp_done[k]  = (em && pos == n - 1) ? 1 : 0;
      if (em) emitted[k]++;
    end
  endtask

  task automatic check_all();
    chk("a.phase",  32'(phase_a),  32'(exp_phase[0]));
    chk("a.done",   32'(done_a),   32'(exp_done[0]));
    chk("a.count",  32'(count_a),  32'((emitted[0] / NP[0]) % (1 << CW[0])));
    chk("a.halted", 32'(halted_a), 32'(m_halted[0]));
    chk("b.phase",  32'(phase_b),  32'(exp_phase[1]));
    chk("b.done",   32'(done_b),   32'(exp_done[1]));
    chk("b.count",  32'(count_b),  32'((emitted[1] / NP[1]) % (1 << CW[1])));
    chk("b.halted", 32'(halted_b), 32'(m_halted[1]));
    chk("c.phase",  32'(phase_c),  32'(exp_phase[2]));
    chk("c.done",   32'(done_c),   32'(exp_done[2]));
    chk("c.count",  32'(count_c),  32'((emitted[2] / NP[2]) % (1 << CW[2])));
    chk("c.halted", 32'(halted_c), 32'(m_halted[2]));
  endtask

  task automatic tick(input logic r, input logic h, input logic s);
    reset = r; halt = h; step = s;
    @(posedge clk);
    #1;
    model_step(r, h, s);
    check_all();
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; step = 1'b0;
    for (int k = 0; k < 3; k++) begin
      emitted[k] = 0; m_halted[k] = 0; m_stepping[k] = 0;
      exp_phase[k] = 0; exp_done[k] = 0;
    end

    // Reset for two clocks: everything zero.
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("rst.phase_a", 32'(phase_a), 0);
    chk("rst.count_b", 32'(count_b), 0);

    // First edge after reset emits phase[0]; nine clocks give three cycles on a.
    tick(0, 0, 0);
    chk("first.phase_a", 32'(phase_a), 32'h1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0);
    chk("nine.phase_a", 32'(phase_a), 32'h4);
    chk("nine.done_a",  32'(done_a),  1);
    chk("nine.count_a", 32'(count_a), 3);

    // b and c now show 0010; raise halt.
    tick(0, 0, 0);
    chk("pre.phase_c", 32'(phase_c), 32'h2);
    tick(0, 1, 0);
    chk("imm.phase_b",  32'(phase_b),  0);
    chk("imm.halted_b", 32'(halted_b), 1);
    chk("bnd.phase_c",  32'(phase_c),  32'h4);
    tick(0, 1, 0);
    chk("bnd.phase_c2", 32'(phase_c), 32'h8);
    tick(0, 1, 0);
    chk("bnd.halted_c", 32'(halted_c), 1);
    chk("bnd.phase_c3", 32'(phase_c),  0);

    // Drop halt: c restarts at 0001, b resumes mid-cycle at 0100.
    tick(0, 0, 0);
    chk("res.phase_c",  32'(phase_c),  32'h1);
    chk("res.halted_c", 32'(halted_c), 0);
    chk("res.phase_b",  32'(phase_b),  32'h4);
    chk("res.count_b",  32'(count_b),  2);

    // Halt a at a boundary, then single-step one full cycle.
    for (int i = 0; i < 4; i++) tick(0, 1, 0);
    chk("stp.halted_a", 32'(halted_a), 1);
    tick(0, 1, 1);
    chk("stp.p0", 32'(phase_a), 32'h1);
    tick(0, 1, 0);
    chk("stp.p1", 32'(phase_a), 32'h2);
    tick(0, 1, 0);
    chk("stp.p2",     32'(phase_a),  32'h4);
    chk("stp.halted", 32'(halted_a), 1);
    chk("stp.count",  32'(count_a),  6);
    tick(0, 1, 0);
    chk("stp.idle", 32'(phase_a), 0);

    // Reset while mid-step, then release.
    tick(0, 1, 1);
    tick(0, 1, 0);
    chk("mid.phase_a", 32'(phase_a), 32'h2);
    tick(1, 1, 0);
    chk("rs.phase_a",  32'(phase_a),  0);
    chk("rs.halted_a", 32'(halted_a), 0);
    chk("rs.count_a",  32'(count_a),  0);
    tick(0, 0, 0);
    chk("rs.first_a", 32'(phase_a), 32'h1);

    // Randomised run: bursty halt, frequent step, rare reset.
    begin
      logic h;
      h = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 7) == 0) h = ~h;
        tick(($urandom_range(0, 79) == 0), h, ($urandom_range(0, 3) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
